vid_stream_gen: RTL

- Synthesizable video stream source: the transmitter side of the pixel stream interface consumed by scaler_v / scaler_h.
- Emits frames of configurable size, with optional per-pixel sparsity and inter-line/inter-frame gaps.
- Marks line and frame starts with one-cycle hs/vs pulses.
- Used as an on-chip test pattern source in front of the scalers and as a bench driver.

---
 rtl/vid_stream_pkg.sv | 22 ++
 rtl/vid_stream_pattern.sv | 32 +++
 rtl/vid_stream_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vid_stream_pkg.sv
// Shared types and constants for the video stream source.
// Pure declarations; no logic, no latency.
package vid_stream_pkg;

   typedef enum logic [1:0] {
      PAT_NIBBLE = 2'd0,
      PAT_SUM    = 2'd1,
      PAT_X      = 2'd2,
      PAT_CONST  = 2'd3
   } pattern_t;

   typedef enum logic [2:0] {
      IDLE,
      PIX,
      SPARSE,
      LGAP,
      FGAP
   } state_t;

   localparam logic [7:0] PAT_CONST_VAL = 8'h5A;

endpackage

// File: rtl/vid_stream_pattern.sv
// Test pattern pixel value from the current x/y position and pattern select.
// Latency: combinational; backpressure: none.
module vid_stream_pattern
   import vid_stream_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int SIZE_WIDTH  = 16
) (
   input  logic [SIZE_WIDTH-1:0]  x,
   input  logic [SIZE_WIDTH-1:0]  y,
   input  logic [1:0]             pattern,
   output logic [PIXEL_WIDTH-1:0] pix
);

   localparam int HW = PIXEL_WIDTH / 2;

   logic [SIZE_WIDTH-1:0] x_inc;

   assign x_inc = x + SIZE_WIDTH'(1);

   always_comb begin
      pix = '0;
      case (pattern_t'(pattern))
         PAT_NIBBLE: pix = {HW'(y), HW'(x_inc)};
         PAT_SUM:    pix = PIXEL_WIDTH'(x) + PIXEL_WIDTH'(y) + PIXEL_WIDTH'(1);
         PAT_X:      pix = PIXEL_WIDTH'(x);
         PAT_CONST:  pix = PIXEL_WIDTH'(PAT_CONST_VAL);
         default:    pix = '0;
      endcase
   end

endmodule

// File: rtl/vid_stream_gen.sv
// Pixel stream source: frames of configurable size with sparsity and line/frame gaps.
// Latency: first pixel two edges after start (busy one edge after); backpressure: none, free-running.
module vid_stream_gen
   import vid_stream_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 8,
   parameter int SIZE_WIDTH   = 16,
   parameter int SPARSE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [SIZE_WIDTH-1:0]   line_size,
   input  logic [SIZE_WIDTH-1:0]   line_count,
   input  logic [SPARSE_WIDTH-1:0] de_period,
   input  logic [SIZE_WIDTH-1:0]   line_gap,
   input  logic [SIZE_WIDTH-1:0]   frame_gap,
   input  logic [SIZE_WIDTH-1:0]   frame_num,
   input  logic [1:0]              pattern,
   output logic [PIXEL_WIDTH-1:0]  do_o,
   output logic                    de_o,
   output logic                    hs_o,
   output logic                    vs_o,
   output logic                    busy_o,
   output logic                    done_o
);

   state_t state, state_nxt;

   logic [SIZE_WIDTH-1:0]   cfg_ls, cfg_lc, cfg_lg, cfg_fg, cfg_fn;
   logic [SPARSE_WIDTH-1:0] cfg_dp;
   logic [1:0]              cfg_pat;

   logic [SIZE_WIDTH-1:0] x, y, x_nxt, y_nxt;
   logic [SIZE_WIDTH-1:0] gcnt, gcnt_nxt, gap_len;
   logic [SIZE_WIDTH-1:0] frame_cnt, frame_nxt;
   logic                  stop_pend, fin_r, fin_nxt;
   logic                  start_acc, last_x, last_y, count_hit, finish, gap_end;
   logic                  route, line_end, frame_end;
   logic [PIXEL_WIDTH-1:0] pix;

   assign start_acc = (state == IDLE) && !busy_o && start;
   assign last_x    = (x == cfg_ls);
   assign last_y    = (y == cfg_lc);
   assign count_hit = (cfg_fn != '0) && ((frame_cnt + SIZE_WIDTH'(1)) == cfg_fn);
   // In PIX the frame counter has not yet absorbed the frame being closed.
   assign finish    = stop_pend || stop || ((state == PIX) ? count_hit : fin_r);

   always_comb begin
      gap_len = '0;
      case (state)
         SPARSE:  gap_len = SIZE_WIDTH'(cfg_dp);
         LGAP:    gap_len = cfg_lg;
         FGAP:    gap_len = cfg_fg;
         default: gap_len = '0;
      endcase
   end

   assign gap_end = (gcnt == (gap_len - SIZE_WIDTH'(1)));

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      frame_nxt = frame_cnt;
      fin_nxt   = fin_r;
      route     = 1'b0;
      line_end  = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (start_acc) begin
               state_nxt = PIX;
               x_nxt     = '0;
               y_nxt     = '0;
               frame_nxt = '0;
               fin_nxt   = 1'b0;
            end
         end
         PIX: begin
            x_nxt = last_x ? '0 : x + SIZE_WIDTH'(1);
            if (last_x)
               y_nxt = last_y ? '0 : y + SIZE_WIDTH'(1);
            if (last_x && last_y) begin
               frame_nxt = frame_cnt + SIZE_WIDTH'(1);
               fin_nxt   = count_hit;
            end
            if (cfg_dp != '0) begin
               state_nxt = SPARSE;
            end else begin
               route     = 1'b1;
               line_end  = last_x;
               frame_end = last_x && last_y;
            end
         end
         SPARSE: begin
            // Counters already wrapped, so x==0 here means the pixel closed a line.
            if (gap_end) begin
               route     = 1'b1;
               line_end  = (x == '0);
               frame_end = (x == '0) && (y == '0);
            end
         end
         LGAP: begin
            if (gap_end)
               state_nxt = PIX;
         end
         FGAP: begin
            if (gap_end)
               state_nxt = finish ? IDLE : PIX;
         end
         default: state_nxt = IDLE;
      endcase
      if (route) begin
         if (frame_end)
            state_nxt = (cfg_fg != '0) ? FGAP : (finish ? IDLE : PIX);
         else if (line_end)
            state_nxt = (cfg_lg != '0) ? LGAP : PIX;
         else
            state_nxt = PIX;
      end
   end

   assign gcnt_nxt = (state_nxt == state) ? gcnt + SIZE_WIDTH'(1) : '0;

   vid_stream_pattern #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .SIZE_WIDTH  (SIZE_WIDTH)
   ) u_pattern (
      .x       (x),
      .y       (y),
      .pattern (cfg_pat),
      .pix     (pix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         gcnt      <= '0;
         frame_cnt <= '0;
         fin_r     <= 1'b0;
         stop_pend <= 1'b0;
         cfg_ls    <= '0;
         cfg_lc    <= '0;
         cfg_dp    <= '0;
         cfg_lg    <= '0;
         cfg_fg    <= '0;
         cfg_fn    <= '0;
         cfg_pat   <= '0;
      end else begin
         state     <= state_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         gcnt      <= gcnt_nxt;
         frame_cnt <= frame_nxt;
         fin_r     <= fin_nxt;
         if (start_acc)
            stop_pend <= stop;
         else if ((state != IDLE) && stop)
            stop_pend <= 1'b1;
         if (start_acc) begin
            cfg_ls  <= line_size;
            cfg_lc  <= line_count;
            cfg_dp  <= de_period;
            cfg_lg  <= line_gap;
            cfg_fg  <= frame_gap;
            cfg_fn  <= frame_num;
            cfg_pat <= pattern;
         end
      end
   end

   // Outputs trail the state by one edge so that every port is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         do_o   <= '0;
         de_o   <= 1'b0;
         hs_o   <= 1'b0;
         vs_o   <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         de_o <= (state == PIX);
         hs_o <= (state == PIX) && (x == '0);
         vs_o <= (state == PIX) && (x == '0) && (y == '0);
         if (state == PIX)
            do_o <= pix;
         if (start_acc)
            busy_o <= 1'b1;
         else if (state == IDLE)
            busy_o <= 1'b0;
         done_o <= (state == IDLE) && busy_o;
      end
   end

endmodule
